// File: rtl/mash_mmd_divider_if.sv
// Handshake bundle between the MASH modulator side and the multi-modulus divider.
// The master drives enable and the modulus offset; the slave returns timing and averaging results.
interface mash_mmd_divider_if #(
    parameter int MOD_W = 4,
    parameter int SUM_W = 16
);
    logic             en;
    logic [MOD_W-1:0] mod_in;
    logic             mod_req;
    logic             div_out;
    logic             div_pulse;
    logic [SUM_W-1:0] sum_out;
    logic             sum_valid;
    logic             clamp_flag;

    modport master (
        output en, mod_in,
        input  mod_req, div_out, div_pulse, sum_out, sum_valid, clamp_flag
    );

    modport slave (
        input  en, mod_in,
        output mod_req, div_out, div_pulse, sum_out, sum_valid, clamp_flag
    );
endinterface

// File: rtl/mash_mmd_divider.sv
// Multi-modulus divider: divides clk by N = BASE_DIV + mod_in, one modulus per period.
// Also sums N over 2^WIN_LOG2 periods so the average fractional ratio can be read back.
module mash_mmd_divider #(
    parameter int BASE_DIV = 16,
    parameter int MIN_DIV  = 4,
    parameter int MOD_W    = 4,
    parameter int CNT_W    = 6,
    parameter int WIN_LOG2 = 10
) (
    input logic               clk,
    input logic               rst_n,
    mash_mmd_divider_if.slave bus
);
    localparam int NW    = CNT_W + 1;
    localparam int ACC_W = CNT_W + WIN_LOG2;
    localparam logic [NW-1:0] BASE_K = NW'(BASE_DIV);
    localparam logic [NW-1:0] MIN_K  = NW'(MIN_DIV);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, n_q, n_new;
    logic [NW-1:0]       n_raw;
    logic                clamp_hit, req, pulse, run, stop;
    logic [ACC_W-1:0]    acc_q, acc_nx, sum_q;
    logic [WIN_LOG2-1:0] win_q;
    logic                sum_valid_q, clamp_q;

    assign n_raw     = BASE_K + NW'(bus.mod_in);
    assign clamp_hit = n_raw < MIN_K;
    assign n_new     = CNT_W'(clamp_hit ? MIN_K : n_raw);
    assign run       = state_q == RUN;
    assign stop      = run && !bus.en;
    assign acc_nx    = acc_q + ACC_W'(n_q);

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        pulse   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.en) begin
                    req     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                pulse = cnt_q == '0;
                req   = pulse;
                if (!bus.en) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            win_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            clamp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_valid_q <= 1'b0;
            if (req) begin
                n_q   <= n_new;
                cnt_q <= n_new - CNT_W'(1);
                if (clamp_hit) clamp_q <= 1'b1;
            end else if (run) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (pulse && bus.en) begin
                win_q <= win_q + WIN_LOG2'(1);
                if (&win_q) begin
                    sum_q       <= acc_nx;
                    sum_valid_q <= 1'b1;
                    acc_q       <= '0;
                end else begin
                    acc_q <= acc_nx;
                end
            end
            // Leaving RUN abandons the window; the last published sum stays.
            if (stop) begin
                acc_q   <= '0;
                win_q   <= '0;
                clamp_q <= 1'b0;
            end
        end
    end

    // The IDLE start strobe follows en directly, so reset must mask it.
    assign bus.mod_req    = req & rst_n;
    assign bus.div_pulse  = pulse;
    assign bus.div_out    = run && (cnt_q >= (n_q >> 1));
    assign bus.sum_out    = sum_q;
    assign bus.sum_valid  = sum_valid_q;
    assign bus.clamp_flag = clamp_q;
endmodule

// File: tb/tb_mash_mmd_divider.sv
// Randomized self-checking bench for mash_mmd_divider.
// Periods, duty, window sum and clamp behaviour are checked against a period-level model.
module tb_mash_mmd_divider;
    localparam int SUM_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mash_mmd_divider_if #(.MOD_W(4), .SUM_W(SUM_W)) dif ();
    mash_mmd_divider_if #(.MOD_W(4), .SUM_W(SUM_W)) cif ();

    mash_mmd_divider u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    mash_mmd_divider #(.BASE_DIV(0), .MIN_DIV(4)) u_clamp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cif)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_n(input int base, input int m);
        return (base + m < 4) ? 4 : base + m;
    endfunction

    // MASH-111 reference, 16-bit accumulators
    int unsigned a1 = 0, a2 = 0, a3 = 0;
    int c2d = 0, c3d = 0, c3dd = 0;

    function automatic int mash_step();
        int c1, c2, c3, o;
        a1 = a1 + 32000;
        c1 = int'(a1 >> 16);
        a1 = a1 & 32'hFFFF;
        a2 = a2 + a1;
        c2 = int'(a2 >> 16);
        a2 = a2 & 32'hFFFF;
        a3 = a3 + a2;
        c3 = int'(a3 >> 16);
        a3 = a3 & 32'hFFFF;
        o = c1 + c2 - c2d + c3 - 2 * c3d + c3dd;
        c3dd = c3d;
        c3d  = c3;
        c2d  = c2;
        return o;
    endfunction

    task automatic run_periods(input string tag, input int mods[$], input bit rel);
        int len, hi, extra, n;
        dif.en = 1'b1;
        if (rel) rst_n = 1'b1;
        #1;
        chk($sformatf("%s_entry_req", tag), dif.mod_req, 1);
        dif.mod_in = 4'(mods[0]);
        foreach (mods[k]) begin
            len = 0;
            hi = 0;
            extra = 0;
            forever begin
                @(negedge clk);
                len++;
                if (dif.div_out) hi++;
                if (dif.div_pulse || len >= 64) break;
                if (dif.mod_req) extra++;
                dif.mod_in = 4'($urandom);
            end
            n = exp_n(16, mods[k]);
            chk($sformatf("%s_period%0d", tag, k), len, n);
            chk($sformatf("%s_high%0d", tag, k), hi, (n + 1) / 2);
            chk($sformatf("%s_req_at_pulse%0d", tag, k), dif.mod_req, 1);
            chk($sformatf("%s_stray_req%0d", tag, k), extra, 0);
            if (k + 1 < mods.size()) dif.mod_in = 4'(mods[k + 1]);
            else dif.mod_in = 4'($urandom);
        end
    endtask

    task automatic stop(input string tag);
        dif.en = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_idle_outs", tag),
            {dif.div_out, dif.div_pulse, dif.mod_req}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int q[$];
        int nq[$];
        int m, len, n, cn;
        int unsigned esum, saved;
        bit got;

        rst_n = 1'b0;
        dif.en = 1'b0;
        dif.mod_in = '0;
        cif.en = 1'b0;
        cif.mod_in = '0;
        #1;
        chk("reset_outs", {dif.mod_req, dif.div_out, dif.div_pulse,
                           dif.sum_valid, dif.clamp_flag, dif.sum_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req", dif.mod_req, 0);

        q = {8, 8, 8, 8};
        run_periods("t2", q, 0);
        stop("t2");

        q = {8, 9, 5, 12};
        run_periods("t3", q, 0);
        stop("t3");

        q = {};
        for (int i = 0; i < 6; i++) q.push_back(int'($urandom_range(0, 15)));
        run_periods("rnd", q, 0);
        stop("rnd");

        // Reset mid-RUN with en still high
        q = {8};
        run_periods("t1pre", q, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t1_async_outs", {dif.mod_req, dif.div_out, dif.div_pulse,
                              dif.sum_valid, dif.clamp_flag, dif.sum_out}, 0);
        @(negedge clk);
        chk("t1_held_outs", {dif.mod_req, dif.div_out, dif.div_pulse}, 0);
        q = {9, 8};
        run_periods("t1", q, 1);
        stop("t1");

        // Ratio over one full window
        dif.en = 1'b1;
        #1;
        chk("t4_entry_req", dif.mod_req, 1);
        m = 8 + mash_step();
        dif.mod_in = 4'(m);
        nq = {};
        nq.push_back(16 + m);
        got = 1'b0;
        for (int c = 0; c < 40000 && !got; c++) begin
            @(negedge clk);
            if (dif.sum_valid) begin
                got = 1'b1;
            end else if (dif.mod_req) begin
                m = 8 + mash_step();
                dif.mod_in = 4'(m);
                nq.push_back(16 + m);
            end else begin
                dif.mod_in = 4'($urandom);
            end
        end
        chk("t4_valid_seen", got, 1);
        esum = 0;
        for (int i = 0; i < 1024 && i < nq.size(); i++) esum += nq[i];
        chk("t4_sum", dif.sum_out, esum);
        chk("t4_ratio_window", (dif.sum_out >= 25066) && (dif.sum_out <= 25085), 1);
        saved = dif.sum_out;
        @(negedge clk);
        chk("t4_valid_oneshot", dif.sum_valid, 0);
        stop("t4");

        // Drop en at cnt=7 of N=24
        dif.en = 1'b1;
        dif.mod_in = 4'd8;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            dif.mod_in = 4'($urandom);
        end
        chk("t6_low_phase", dif.div_out, 0);
        dif.en = 1'b0;
        @(negedge clk);
        chk("t6_idle_outs", {dif.div_out, dif.div_pulse, dif.mod_req}, 0);
        chk("t6_sum_held", dif.sum_out, saved);
        chk("t6_no_valid", dif.sum_valid, 0);
        q = {8, 8};
        run_periods("t6re", q, 0);
        stop("t6");
        chk("main_no_clamp", dif.clamp_flag, 0);

        // Clamp on the BASE_DIV=0 instance
        cif.en = 1'b1;
        cif.mod_in = 4'd2;
        #1;
        chk("t5_entry_req", cif.mod_req, 1);
        q = {2, 2, 10, 2};
        foreach (q[k]) begin
            len = 0;
            forever begin
                @(negedge clk);
                len++;
                if (cif.div_pulse || len >= 64) break;
                cif.mod_in = 4'($urandom_range(4, 15));
            end
            n = exp_n(0, q[k]);
            chk($sformatf("t5_period%0d", k), len, n);
            chk($sformatf("t5_clamp%0d", k), cif.clamp_flag, 1);
            chk($sformatf("t5_req%0d", k), cif.mod_req, 1);
            cn = (k + 1 < q.size()) ? q[k + 1] : 8;
            cif.mod_in = 4'(cn);
        end
        cif.en = 1'b0;
        @(negedge clk);
        chk("t5_clamp_cleared", cif.clamp_flag, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
